ofs_plat_ccip_c1_wr_rsp_packer: RTL and testbench

// - Sits between the FIU CCI-P c1 channel and the CCI-P-to-AXI host-memory mapper.
// - Converts every multi-line write completion into exactly one packed response
//   (format=1, cl_num=len-1), so the mapper receives one response per request.
// - Snoops c1Tx write requests to learn each tag's line count. Counts unpacked
//   (format=0) per-line FIU responses and emits a single packed response on the last line.
// - Forwards all other c1Rx responses (fence, interrupt, already-packed) in order.

---
 rtl/ofs_plat_ccip_c1_wr_rsp_packer_pkg.sv | 43 ++++
 rtl/ofs_plat_ccip_c1_wr_rsp_packer_tbl.sv | 19 +
 rtl/ofs_plat_ccip_c1_wr_rsp_packer.sv | 80 ++++++++
 tb/tb_ofs_plat_ccip_c1_wr_rsp_packer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ofs_plat_ccip_c1_wr_rsp_packer_pkg.sv
// ofs_plat_ccip_c1_wr_rsp_packer_pkg: CCI-P c1 types and write-response packing helpers
package ofs_plat_ccip_c1_wr_rsp_packer_pkg;
  typedef logic [1:0] t_ccip_clLen;
  localparam t_ccip_clLen eCL_LEN_1 = 2'd0;
  localparam t_ccip_clLen eCL_LEN_2 = 2'd1;
  localparam t_ccip_clLen eCL_LEN_4 = 2'd3;
  typedef logic [3:0] t_ccip_c1_req;
  localparam t_ccip_c1_req eREQ_WRLINE_I = 4'h0;
  localparam t_ccip_c1_req eREQ_WRLINE_M = 4'h1;
  localparam t_ccip_c1_req eREQ_WRFENCE = 4'h4;
  localparam t_ccip_c1_req eREQ_INTR = 4'h6;
  typedef logic [3:0] t_ccip_c1_rsp;
  localparam t_ccip_c1_rsp eRSP_WRLINE = 4'h0;
  localparam t_ccip_c1_rsp eRSP_WRFENCE = 4'h4;
  localparam t_ccip_c1_rsp eRSP_INTR = 4'h6;
  typedef logic [15:0] t_ccip_mdata;
  typedef struct packed {
    t_ccip_c1_req req_type;
    logic sop;
    t_ccip_clLen cl_len;
    t_ccip_mdata mdata;
  } t_ccip_c1_ReqMemHdr;
  typedef struct packed {
    t_ccip_c1_rsp resp_type;
    logic format;
    t_ccip_clLen cl_num;
    t_ccip_mdata mdata;
  } t_ccip_c1_RspMemHdr;
  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic rspValid;
  } t_if_ccip_c1_Rx;
  typedef struct packed {
    t_ccip_clLen exp_len;
    logic [1:0] rcv_cnt;
  } t_ccip_wr_pack_entry;
  function automatic logic ccip_c1Rx_isPackedWriteRsp(t_if_ccip_c1_Rx rx);
    return rx.rspValid && rx.hdr.resp_type == eRSP_WRLINE && rx.hdr.format;
  endfunction
  function automatic logic ccip_c1Rx_isUnpackedWriteRsp(t_if_ccip_c1_Rx rx);
    return rx.rspValid && rx.hdr.resp_type == eRSP_WRLINE && !rx.hdr.format;
  endfunction
endpackage

// File: rtl/ofs_plat_ccip_c1_wr_rsp_packer_tbl.sv
// ofs_plat_ccip_c1_wr_rsp_packer_tbl: per-tag length/count table with write-through read bypass
module ofs_plat_ccip_c1_wr_rsp_packer_tbl
  import ofs_plat_ccip_c1_wr_rsp_packer_pkg::*;
#(
  parameter int TAG_WIDTH = 9
) (
  input logic clk,
  input logic wr_en,
  input logic [TAG_WIDTH-1:0] wr_idx,
  input t_ccip_wr_pack_entry wr_data,
  input logic [TAG_WIDTH-1:0] rd_idx,
  output t_ccip_wr_pack_entry rd_data
);
  t_ccip_wr_pack_entry mem [2**TAG_WIDTH];
  // single write port, no reset: entries are initialised when a request is recorded
  always_ff @(posedge clk) if (wr_en) mem[wr_idx] <= wr_data;
  // registered read; a same-cycle write to the same tag is forwarded so the reader never sees stale data
  always_ff @(posedge clk) rd_data <= (wr_en && wr_idx == rd_idx) ? wr_data : mem[rd_idx];
endmodule

// File: rtl/ofs_plat_ccip_c1_wr_rsp_packer.sv
// ofs_plat_ccip_c1_wr_rsp_packer: merge per-line c1 write completions into one packed response per request
module ofs_plat_ccip_c1_wr_rsp_packer
  import ofs_plat_ccip_c1_wr_rsp_packer_pkg::*;
#(
  parameter int TAG_WIDTH = 9,
  parameter int CHECK_ERRORS = 1
) (
  input logic clk,
  input logic reset_n,
  input logic c1Tx_valid,
  input t_ccip_c1_ReqMemHdr c1Tx_hdr,
  input t_if_ccip_c1_Rx fiu_c1Rx,
  output t_if_ccip_c1_Rx afu_c1Rx,
  output logic err_unexpected
);
  typedef logic [TAG_WIDTH-1:0] t_tag;
  logic [2**TAG_WIDTH-1:0] busy, busy_d;
  logic rec, s2_valid, s2_busy, s2_pk, s2_upk, last, bad, upd, clr, emit, out_valid, tbl_wr, unused;
  t_tag rec_tag, s1_tag, s2_tag, tbl_idx;
  t_ccip_c1_RspMemHdr s2_hdr, out_hdr, out_hdr_d;
  t_ccip_wr_pack_entry s2_ent, tbl_wdata;
  t_if_ccip_c1_Rx s2_rx;
  assign unused = ^c1Tx_hdr.mdata[15:TAG_WIDTH];
  assign rec = c1Tx_valid && c1Tx_hdr.sop &&
               (c1Tx_hdr.req_type == eREQ_WRLINE_I || c1Tx_hdr.req_type == eREQ_WRLINE_M);
  assign rec_tag = c1Tx_hdr.mdata[TAG_WIDTH-1:0];
  assign s1_tag = fiu_c1Rx.hdr.mdata[TAG_WIDTH-1:0];
  assign s2_tag = s2_hdr.mdata[TAG_WIDTH-1:0];
  assign s2_rx = '{hdr: s2_hdr, rspValid: s2_valid};
  assign s2_pk = ccip_c1Rx_isPackedWriteRsp(s2_rx);
  assign s2_upk = ccip_c1Rx_isUnpackedWriteRsp(s2_rx);
  assign last = s2_ent.rcv_cnt == s2_ent.exp_len;
  assign bad = (CHECK_ERRORS != 0) && (s2_pk || s2_upk) &&
               (!s2_busy || (s2_upk && (s2_ent.rcv_cnt > s2_ent.exp_len || s2_hdr.cl_num != s2_ent.rcv_cnt)));
  assign upd = s2_upk && !bad && !last;
  assign clr = (s2_pk || (s2_upk && last)) && !bad;
  assign emit = s2_valid && !bad && !upd;
  assign out_hdr_d = s2_upk ? t_ccip_c1_RspMemHdr'{resp_type: s2_hdr.resp_type, format: 1'b1,
                                                   cl_num: s2_ent.exp_len, mdata: s2_hdr.mdata} : s2_hdr;
  // recording a new request outranks the counter update on the shared write port
  assign tbl_wr = rec || upd;
  assign tbl_idx = rec ? rec_tag : s2_tag;
  assign tbl_wdata = rec ? t_ccip_wr_pack_entry'{exp_len: c1Tx_hdr.cl_len, rcv_cnt: 2'd0}
                         : t_ccip_wr_pack_entry'{exp_len: s2_ent.exp_len, rcv_cnt: s2_ent.rcv_cnt + 2'd1};
  // next busy vector: a record on a tag freed this same cycle leaves it busy
  always_comb begin
    busy_d = busy;
    if (clr) busy_d[s2_tag] = 1'b0;
    if (rec) busy_d[rec_tag] = 1'b1;
  end
  ofs_plat_ccip_c1_wr_rsp_packer_tbl #(.TAG_WIDTH(TAG_WIDTH)) tbl (
    .clk(clk),
    .wr_en(tbl_wr),
    .wr_idx(tbl_idx),
    .wr_data(tbl_wdata),
    .rd_idx(s1_tag),
    .rd_data(s2_ent)
  );
  // control state: valids, busy flags and the sticky error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
      s2_valid <= 1'b0;
      out_valid <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      busy <= busy_d;
      s2_valid <= fiu_c1Rx.rspValid;
      out_valid <= emit;
      err_unexpected <= err_unexpected || bad;
    end
  end
  // datapath registers; busy is sampled from the next-state vector so back-to-back beats see fresh state
  always_ff @(posedge clk) begin
    s2_hdr <= fiu_c1Rx.hdr;
    s2_busy <= busy_d[s1_tag];
    out_hdr <= out_hdr_d;
  end
  assign afu_c1Rx = '{hdr: out_hdr, rspValid: out_valid};
endmodule

// File: tb/tb_ofs_plat_ccip_c1_wr_rsp_packer.sv
// tb_ofs_plat_ccip_c1_wr_rsp_packer: directed bench with a transaction-level packing model
module tb_ofs_plat_ccip_c1_wr_rsp_packer;
  import ofs_plat_ccip_c1_wr_rsp_packer_pkg::*;
  logic clk = 0;
  logic reset_n = 1;
  logic c1Tx_valid = 0;
  t_ccip_c1_ReqMemHdr c1Tx_hdr = '0;
  t_if_ccip_c1_Rx fiu_c1Rx = '0;
  t_if_ccip_c1_Rx afu_c1Rx;
  logic err_unexpected;
  int cyc = 0;
  int n_vec = 0;
  int n_fail = 0;
  typedef struct { int cyc; t_ccip_c1_RspMemHdr hdr; } t_exp;
  t_exp exp_q[$];
  t_exp e_cur;
  int obs_cyc[$];
  t_ccip_c1_RspMemHdr obs_hdr[$];
  bit mbusy[512];
  int mcnt[512];
  int mexp[512];
  int err_due = -1;
  int k0, n0;

  ofs_plat_ccip_c1_wr_rsp_packer dut (
    .clk(clk),
    .reset_n(reset_n),
    .c1Tx_valid(c1Tx_valid),
    .c1Tx_hdr(c1Tx_hdr),
    .fiu_c1Rx(fiu_c1Rx),
    .afu_c1Rx(afu_c1Rx),
    .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // every cycle out of reset: error flag and output stream against the model queue
  always @(negedge clk) if (reset_n) begin
    check("err_unexpected", err_unexpected, (err_due >= 0 && cyc >= err_due));
    if (afu_c1Rx.rspValid) begin
      obs_cyc.push_back(cyc);
      obs_hdr.push_back(afu_c1Rx.hdr);
      if (exp_q.size() == 0) check("unexpected_rsp", exp_q.size(), 1);
      else begin
        e_cur = exp_q.pop_front();
        check("rsp_hdr", afu_c1Rx.hdr, e_cur.hdr);
        check("rsp_cycle", cyc, e_cur.cyc);
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      check("missing_rsp", afu_c1Rx.rspValid, 1);
      void'(exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    c1Tx_valid = 0;
    c1Tx_hdr = '0;
    fiu_c1Rx = '0;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic req(t_ccip_c1_req ty, logic sop, t_ccip_clLen len, int tag);
    c1Tx_valid = 1;
    c1Tx_hdr = '{req_type: ty, sop: sop, cl_len: len, mdata: 16'(tag)};
    if (sop && (ty == eREQ_WRLINE_I || ty == eREQ_WRLINE_M)) begin
      mbusy[tag % 512] = 1;
      mcnt[tag % 512] = 0;
      mexp[tag % 512] = int'(len);
    end
    tick();
  endtask

  // one beat from the FIU; the model resolves it immediately and schedules any output 2 cycles on
  task automatic rsp(t_ccip_c1_rsp ty, logic fmt, t_ccip_clLen cl, int md);
    t_ccip_c1_RspMemHdr h;
    int t;
    h = '{resp_type: ty, format: fmt, cl_num: cl, mdata: 16'(md)};
    t = md % 512;
    fiu_c1Rx = '{hdr: h, rspValid: 1'b1};
    if (ty != eRSP_WRLINE) exp_q.push_back('{cyc + 2, h});
    else if (!mbusy[t] || (!fmt && int'(cl) != mcnt[t])) begin
      if (err_due < 0) err_due = cyc + 2;
    end else if (fmt) begin
      exp_q.push_back('{cyc + 2, h});
      mbusy[t] = 0;
    end else if (mcnt[t] == mexp[t]) begin
      h.format = 1'b1;
      h.cl_num = t_ccip_clLen'(mexp[t]);
      exp_q.push_back('{cyc + 2, h});
      mbusy[t] = 0;
    end else mcnt[t]++;
    tick();
  endtask

  task automatic do_reset();
    reset_n = 0;
    #1;
    check("rst_rspValid", afu_c1Rx.rspValid, 0);
    check("rst_err", err_unexpected, 0);
    check("rst_busy_clear", dut.busy == '0, 1);
    exp_q.delete();
    err_due = -1;
    foreach (mbusy[i]) mbusy[i] = 0;
    @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  task automatic pin(string nm, int i, int md, int cl, int fmt, int dt);
    if (i >= obs_hdr.size()) check({nm, "_present"}, obs_hdr.size(), i + 1);
    else begin
      check({nm, "_mdata"}, obs_hdr[i].mdata, md);
      check({nm, "_cl_num"}, obs_hdr[i].cl_num, cl);
      check({nm, "_format"}, obs_hdr[i].format, fmt);
      check({nm, "_latency"}, obs_cyc[i] - k0, dt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2;
    do_reset();
    // packed response passes straight through and frees the tag
    req(eREQ_WRLINE_I, 1, eCL_LEN_4, 5);
    n0 = obs_hdr.size(); k0 = cyc;
    rsp(eRSP_WRLINE, 1, eCL_LEN_4, 5);
    idle(3);
    check("t1_count", obs_hdr.size() - n0, 1);
    pin("t1", n0, 5, 3, 1, 2);
    check("t1_busy5", dut.busy[5], 0);
    // four unpacked lines collapse to one packed response
    req(eREQ_WRLINE_M, 1, eCL_LEN_4, 7);
    n0 = obs_hdr.size(); k0 = cyc;
    for (int i = 0; i < 4; i++) rsp(eRSP_WRLINE, 0, t_ccip_clLen'(i), 7);
    idle(3);
    check("t2_count", obs_hdr.size() - n0, 1);
    pin("t2", n0, 7, 3, 1, 5);
    // back-to-back beats on the same tag, interleaved tags
    req(eREQ_WRLINE_I, 1, eCL_LEN_2, 7);
    req(eREQ_WRLINE_I, 1, eCL_LEN_2, 8);
    n0 = obs_hdr.size(); k0 = cyc;
    rsp(eRSP_WRLINE, 0, 2'd0, 7);
    rsp(eRSP_WRLINE, 0, 2'd1, 7);
    rsp(eRSP_WRLINE, 0, 2'd0, 8);
    rsp(eRSP_WRLINE, 0, 2'd1, 8);
    idle(4);
    check("t3_count", obs_hdr.size() - n0, 2);
    pin("t3a", n0, 7, 1, 1, 3);
    pin("t3b", n0 + 1, 8, 1, 1, 5);
    // fence and interrupt responses mid-burst keep their place in the stream
    req(eREQ_WRLINE_I, 1, eCL_LEN_4, 9);
    n0 = obs_hdr.size(); k0 = cyc;
    rsp(eRSP_WRLINE, 0, 2'd0, 9);
    rsp(eRSP_WRFENCE, 0, 2'd0, 'h1F0);
    rsp(eRSP_WRLINE, 0, 2'd1, 9);
    rsp(eRSP_INTR, 0, 2'd0, 2);
    rsp(eRSP_WRLINE, 0, 2'd2, 9);
    rsp(eRSP_WRLINE, 0, 2'd3, 9);
    idle(3);
    check("t4_count", obs_hdr.size() - n0, 3);
    pin("t4_fence", n0, 'h1F0, 0, 0, 3);
    pin("t4_intr", n0 + 1, 2, 0, 0, 5);
    pin("t4_pack", n0 + 2, 9, 3, 1, 7);
    // re-record a tag in the cycle its completion frees it; upper mdata bits pass through
    req(eREQ_WRLINE_I, 1, eCL_LEN_1, 10);
    n0 = obs_hdr.size(); k0 = cyc;
    rsp(eRSP_WRLINE, 0, 2'd0, 10);
    req(eREQ_WRLINE_I, 1, eCL_LEN_2, 10);
    rsp(eRSP_WRLINE, 0, 2'd0, 'hE0A);
    rsp(eRSP_WRLINE, 0, 2'd1, 'hE0A);
    idle(3);
    check("t7_count", obs_hdr.size() - n0, 2);
    pin("t7a", n0, 10, 0, 1, 2);
    pin("t7b", n0 + 1, 'hE0A, 1, 1, 5);
    // reset in the middle of a burst discards it
    req(eREQ_WRLINE_I, 1, eCL_LEN_4, 3);
    rsp(eRSP_WRLINE, 0, 2'd0, 3);
    rsp(eRSP_WRLINE, 0, 2'd1, 3);
    n0 = obs_hdr.size();
    do_reset();
    req(eREQ_WRLINE_I, 1, eCL_LEN_1, 3);
    k0 = cyc;
    rsp(eRSP_WRLINE, 0, 2'd0, 3);
    idle(3);
    check("t6_count", obs_hdr.size() - n0, 1);
    pin("t6", n0, 3, 0, 1, 2);
    // fence requests and non-sop beats do not record; a response to tag 12 is an error
    req(eREQ_WRFENCE, 1, eCL_LEN_1, 12);
    req(eREQ_WRLINE_I, 0, eCL_LEN_1, 12);
    n0 = obs_hdr.size(); k0 = cyc;
    rsp(eRSP_WRLINE, 0, 2'd0, 12);
    check("t5_err_early", err_unexpected, 0);
    tick();
    check("t5_err_set", err_unexpected, 1);
    idle(5);
    check("t5_err_held", err_unexpected, 1);
    check("t5_count", obs_hdr.size() - n0, 0);
    do_reset();
    idle(2);
    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
